// File: rtl/led_sequencer_if.sv
// led_sequencer_if -- Avalon-MM slave bus for the LED sequencer.
//   address   : word address (4 bits)
//   read      : read strobe; readdata is valid in the same cycle
//   readdata  : 32-bit read data
//   write     : write strobe
//   writedata : 32-bit write data
interface led_sequencer_if;
   logic [3:0]  address;
   logic        read;
   logic [31:0] readdata;
   logic        write;
   logic [31:0] writedata;

   modport master (output address, read, write, writedata, input readdata);
   modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/led_sequencer.sv
// led_sequencer -- plays up to eight 8-bit LED patterns, each held for
// PERIOD+1 cycles, either once or looping. Controlled through a small
// Avalon-MM register file.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : Avalon-MM slave (led_sequencer_if.slave), zero wait states
//   led     : LED drive, IDLEPAT when idle, PAT[STEP] while playing
// Register map (word addresses):
//   0 CTRL    bit0 RUN, bit1 LOOP, bits[6:4] LAST
//   1 STATUS  bit0 BUSY, bit1 DONE (W1C), bits[6:4] STEP
//   2 PERIOD  bits[PERIOD_W-1:0]
//   3 IDLEPAT bits[7:0]
//   8..15     PAT[0..7] bits[7:0]
module led_sequencer #(
   parameter int PERIOD_W = 24
) (
   input  logic              clk,
   input  logic              reset_n,
   led_sequencer_if.slave    bus,
   output logic [7:0]        led
);

   typedef enum logic {IDLE, PLAY} state_t;

   state_t                r_state;
   logic                  r_loop;
   logic [2:0]            r_last;
   logic                  r_done;
   logic [2:0]            r_step;
   logic [PERIOD_W-1:0]   r_period;
   logic [PERIOD_W-1:0]   r_cnt;
   logic [7:0]            r_idlepat;
   logic [7:0][7:0]       r_pat;

   logic                  w_busy;
   logic                  w_adv;
   logic                  w_term;
   logic [31:0]           w_rdata;
   logic                  w_unused;

   assign w_busy = (r_state == PLAY);
   // Step advance happens on the cycle the counter has run down to zero.
   assign w_adv  = w_busy && (r_cnt == '0);
   // Terminal advance: last step done and not looping -> DONE is set.
   assign w_term = w_adv && (r_step >= r_last) && !r_loop;

   // RUN is not stored separately: it is 1 exactly while playing.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_loop    <= 1'b0;
         r_last    <= '0;
         r_done    <= 1'b0;
         r_step    <= '0;
         r_period  <= '0;
         r_cnt     <= '0;
         r_idlepat <= '0;
         r_pat     <= '0;
      end else begin
         if (w_busy) begin
            if (w_adv) begin
               if (r_step >= r_last) begin
                  if (r_loop) begin
                     r_step <= '0;
                     r_cnt  <= r_period;
                  end else begin
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_step <= r_step + 3'd1;
                  r_cnt  <= r_period;
               end
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end

         // Bus writes come after the sequencing logic so a CTRL write
         // overrides any advance in the same cycle.
         if (bus.write) begin
            if (bus.address[3]) begin
               r_pat[bus.address[2:0]] <= bus.writedata[7:0];
            end else begin
               unique case (bus.address[2:0])
                  3'd0: begin
                     r_loop <= bus.writedata[1];
                     r_last <= bus.writedata[6:4];
                     if (bus.writedata[0]) begin
                        r_state <= PLAY;
                        r_step  <= '0;
                        r_cnt   <= r_period;
                        r_done  <= 1'b0;
                     end else if (w_busy) begin
                        // Stop: no DONE, STEP frozen where it was.
                        r_state <= IDLE;
                        r_step  <= r_step;
                        r_done  <= r_done;
                     end
                  end
                  3'd1: if (bus.writedata[1] && !w_term) r_done <= 1'b0;
                  3'd2: r_period  <= bus.writedata[PERIOD_W-1:0];
                  3'd3: r_idlepat <= bus.writedata[7:0];
                  default: ;
               endcase
            end
         end
      end
   end

   assign led = w_busy ? r_pat[r_step] : r_idlepat;

   always_comb begin
      w_rdata = '0;
      if (bus.address[3]) begin
         w_rdata[7:0] = r_pat[bus.address[2:0]];
      end else begin
         unique case (bus.address[2:0])
            3'd0:    w_rdata = {25'd0, r_last, 2'b00, r_loop, w_busy};
            3'd1:    w_rdata = {25'd0, r_step, 2'b00, r_done, w_busy};
            3'd2:    w_rdata = 32'(r_period);
            3'd3:    w_rdata = {24'd0, r_idlepat};
            default: w_rdata = '0;
         endcase
      end
   end

   assign bus.readdata = bus.read ? w_rdata : 32'd0;

   assign w_unused = &{1'b0, bus.writedata};

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter PERIOD_W, default 24, giving the width of the step-duration counter and PERIOD register (range 8..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port address, input, 4, the Avalon-MM slave word address.
REQ-005 SHALL have port read, input, 1, the Avalon-MM read strobe.
REQ-006 SHALL have port readdata, output, 32, the Avalon-MM read data.
REQ-007 SHALL have port write, input, 1, the Avalon-MM write strobe.
REQ-008 SHALL have port writedata, input, 32, the Avalon-MM write data.
REQ-009 SHALL have port led, output, 8, the LED drive.

Function
REQ-010 SHALL use this register map:
- 0 CTRL, RW: bit0 RUN, bit1 LOOP, bits[6:4] LAST (final step index).
- 1 STATUS, RO except DONE: bit0 BUSY, bit1 DONE (sticky, write-1-to-clear), bits[6:4] STEP.
- 2 PERIOD, RW: bits[PERIOD_W-1:0].
- 3 IDLEPAT, RW: bits[7:0].
- 8..15 PAT[0..7], RW: bits[7:0].
REQ-011 SHALL return readdata combinationally with zero wait states; unused bits and unmapped addresses SHALL read 0; read SHALL have no side effects.
REQ-012 SHALL ignore writes to unmapped addresses and to read-only bits.
REQ-013 SHALL implement the FSM states IDLE and PLAY; BUSY is 1 exactly in PLAY.
REQ-014 SHALL drive led combinationally: IDLEPAT in IDLE, PAT[STEP] in PLAY.
REQ-015 SHALL, in each state, on a write to CTRL with RUN=1, enter PLAY on the next edge with STEP=0 and counter=PERIOD; a RUN=1 write while already in PLAY restarts the sequence the same way.
REQ-016 SHALL, in PLAY, decrement the counter each cycle and, at counter==0, perform a step advance; each step lasts PERIOD+1 cycles (PERIOD=0 gives 1 cycle per step).
REQ-017 SHALL perform a step advance as follows:
- If STEP>=LAST and LOOP=1: STEP<=0, reload counter.
- If STEP>=LAST and LOOP=0: go to IDLE, clear RUN, set DONE.
- Otherwise: STEP<=STEP+1, reload counter.
REQ-018 SHALL, on a CTRL write with RUN=0 in PLAY, go to IDLE on the next edge without setting DONE; STEP SHALL hold its value.
REQ-019 SHALL apply a PERIOD write during PLAY at the next counter reload, not to the step in progress.
REQ-020 SHALL make PAT, LOOP and LAST writes during PLAY visible on the next edge; LAST written below the current STEP terminates or loops at the next step advance (per >= compare).
REQ-021 SHALL let DONE set win over a same-cycle DONE-clear write.
REQ-022 SHALL clear DONE on any RUN=1 CTRL write.
REQ-023 SHALL let a RUN=1 CTRL write override a same-cycle terminal advance (restart, DONE not set).

Reset
REQ-024 SHALL, on reset_n low, asynchronously clear CTRL, DONE, STEP, PERIOD, IDLEPAT, all PAT entries and the counter, and enter IDLE; led=0 and readdata=0 for all addresses while in reset.
REQ-025 SHALL, on reset asserted mid-PLAY, abandon the sequence immediately, with no DONE set after release.

Verification
REQ-026 Static: write IDLEPAT=0xA5 -> led=0xA5 from the next cycle; read addr 3 returns 0x000000A5; read addr 5 returns 0.
REQ-027 One-shot: PAT0..2=01,02,04; PERIOD=3; CTRL=0x21 (RUN, LAST=2) -> led 01,02,04 each exactly 4 cycles, then IDLEPAT; STATUS=0x22 (DONE, STEP=2, BUSY=0); CTRL reads 0x20.
REQ-028 Loop: same patterns; CTRL=0x23; PERIOD=0 -> led cycles 01,02,04,01... one cycle each; write CTRL=0x22 -> IDLE next cycle, DONE=0.
REQ-029 Live updates: during PLAY at step 1 write PERIOD=9 -> current step keeps its old length and the next step lasts 10 cycles; then write LAST=0 -> terminates at the next advance.
REQ-030 Races: a DONE-clear write in the terminal-advance cycle -> DONE=1; a RUN=1 write in that cycle -> STEP=0, BUSY=1, DONE=0.
REQ-031 Reset: assert reset_n low mid-PLAY, asynchronous to clk -> led=0 and BUSY=0 immediately; after release, all registers read 0.
